// File: rtl/pi_servo_filter_pkg.sv
// rtl/pi_servo_filter_pkg.sv - shared widths, FSM encoding and DAC rails for the PI servo filter
package pi_servo_filter_pkg;

    localparam int DEF_KP_SHIFT = 8;
    localparam int DEF_I_SHIFT  = 16;
    localparam int DEF_IW       = 40;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUN      = 2'd1,
        ST_HOLD     = 2'd2
    } servo_state_e;

    localparam logic signed [15:0] SAT16_MAX = 16'sh7fff;
    localparam logic signed [15:0] SAT16_MIN = 16'sh8000;

endpackage

// File: rtl/pi_servo_filter_sat_add.sv
// rtl/pi_servo_filter_sat_add.sv - signed adder clamped to a W_O-bit signed range
// Ports: i_a, i_b signed addends; o_y clamped sum; o_ovf set when the clamp engaged.
// The output width must be narrower than max(W_A, W_B) + 1.
module pi_servo_filter_sat_add #(
    parameter int W_A = 16,
    parameter int W_B = 16,
    parameter int W_O = 16
) (
    input  logic signed [W_A-1:0] i_a,
    input  logic signed [W_B-1:0] i_b,
    output logic signed [W_O-1:0] o_y,
    output logic                  o_ovf
);

    localparam int WS = ((W_A > W_B) ? W_A : W_B) + 1;
    localparam logic signed [WS-1:0] MAX_V = {{(WS-W_O+1){1'b0}}, {(W_O-1){1'b1}}};
    localparam logic signed [WS-1:0] MIN_V = {{(WS-W_O+1){1'b1}}, {(W_O-1){1'b0}}};

    logic signed [WS-1:0] w_sum;

    assign w_sum = {{(WS-W_A){i_a[W_A-1]}}, i_a} + {{(WS-W_B){i_b[W_B-1]}}, i_b};

    always_comb begin
        o_y   = w_sum[W_O-1:0];
        o_ovf = 1'b0;
        if (w_sum > MAX_V) begin
            o_y   = MAX_V[W_O-1:0];
            o_ovf = 1'b1;
        end else if (w_sum < MIN_V) begin
            o_y   = MIN_V[W_O-1:0];
            o_ovf = 1'b1;
        end
    end

endmodule

// File: rtl/pi_servo_filter.sv
// rtl/pi_servo_filter.sv - PI loop filter from ADC sample to saturated 16-bit DAC word
// Ports: clk_in/rst_in (sync, active-low); adc_in + adc_valid_in strobe with
// setpoint_in, kp_in, ki_in sampled alongside; offset_in, enable_in, hold_in,
// int_clear_in live controls; dac_out + dac_valid_out strobe (3 cycles after
// the input strobe); railed_out flags a clipped dac_out.
module pi_servo_filter
    import pi_servo_filter_pkg::*;
#(
    parameter int KP_SHIFT = DEF_KP_SHIFT,
    parameter int I_SHIFT  = DEF_I_SHIFT,
    parameter int IW       = DEF_IW
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic signed [15:0] adc_in,
    input  logic               adc_valid_in,
    input  logic signed [15:0] setpoint_in,
    input  logic signed [15:0] kp_in,
    input  logic signed [15:0] ki_in,
    input  logic signed [15:0] offset_in,
    input  logic               enable_in,
    input  logic               hold_in,
    input  logic               int_clear_in,
    output logic signed [15:0] dac_out,
    output logic               dac_valid_out,
    output logic               railed_out
);

    localparam int IO_W  = IW - I_SHIFT;
    localparam int SUM_W = ((33 > IO_W) ? 33 : IO_W) + 1;

    servo_state_e r_state, w_state_next, w_acc_mode;

    logic               r_s1_vld, r_s1_clr;
    logic signed [16:0] r_s1_err;
    logic signed [15:0] r_s1_kp, r_s1_ki;
    servo_state_e       r_s1_mode;

    logic               r_s2_vld, r_s2_clr;
    logic signed [32:0] r_s2_p, r_s2_inc;
    servo_state_e       r_s2_mode;

    logic signed [IW-1:0] r_int;
    logic signed [15:0]   r_dac;
    logic                 r_valid, r_railed;

    logic signed [16:0]    w_err;
    logic signed [32:0]    w_pk, w_p, w_inc;
    logic signed [IW-1:0]  w_base, w_int_sum, w_int_next;
    logic                  w_int_ovf_unused;
    logic signed [IO_W-1:0] w_i_hi;
    logic signed [SUM_W-1:0] w_pi;
    logic signed [15:0]    w_dac_sat;
    logic                  w_dac_ovf, w_windup, w_dis;

    // FSM state register
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= ST_DISABLED;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: moves only when a sample is accepted
    always_comb begin
        w_state_next = r_state;
        if (adc_valid_in) begin
            if (!enable_in) begin
                w_state_next = ST_DISABLED;
            end else begin
                case (r_state)
                    ST_DISABLED: w_state_next = ST_RUN;
                    ST_RUN:      if (hold_in)  w_state_next = ST_HOLD;
                    ST_HOLD:     if (!hold_in) w_state_next = ST_RUN;
                    default:     w_state_next = ST_DISABLED;
                endcase
            end
        end
    end

    // FSM output: an accepted sample travels tagged with the state it enters
    always_comb begin
        w_acc_mode = w_state_next;
    end

    assign w_err = {setpoint_in[15], setpoint_in} - {adc_in[15], adc_in};
    assign w_pk  = $signed({{16{r_s1_err[16]}}, r_s1_err}) * $signed({{17{r_s1_kp[15]}}, r_s1_kp});
    assign w_p   = w_pk >>> KP_SHIFT;
    assign w_inc = $signed({{16{r_s1_err[16]}}, r_s1_err}) * $signed({{17{r_s1_ki[15]}}, r_s1_ki});

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_s1_vld  <= 1'b0;
            r_s1_clr  <= 1'b0;
            r_s1_err  <= '0;
            r_s1_kp   <= '0;
            r_s1_ki   <= '0;
            r_s1_mode <= ST_DISABLED;
            r_s2_vld  <= 1'b0;
            r_s2_clr  <= 1'b0;
            r_s2_p    <= '0;
            r_s2_inc  <= '0;
            r_s2_mode <= ST_DISABLED;
        end else begin
            r_s1_vld <= adc_valid_in;
            if (adc_valid_in) begin
                r_s1_err  <= w_err;
                r_s1_kp   <= kp_in;
                r_s1_ki   <= ki_in;
                r_s1_mode <= w_acc_mode;
                r_s1_clr  <= int_clear_in;
            end
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_p    <= w_p;
                r_s2_inc  <= w_inc;
                r_s2_mode <= r_s1_mode;
                r_s2_clr  <= r_s1_clr;
            end
        end
    end

    // A clear that arrived with this sample makes it start from zero even if
    // older samples touched the integrator since.
    assign w_base = r_s2_clr ? '0 : r_int;

    pi_servo_filter_sat_add #(.W_A(IW), .W_B(33), .W_O(IW)) u_int_add (
        .i_a   (w_base),
        .i_b   (r_s2_inc),
        .o_y   (w_int_sum),
        .o_ovf (w_int_ovf_unused)
    );

    // Stop integrating further into the rail the output is already pinned on.
    assign w_windup = railed_out &&
                      (((r_dac == SAT16_MAX) && !r_s2_inc[32] && (r_s2_inc != '0)) ||
                       ((r_dac == SAT16_MIN) && r_s2_inc[32]));

    // enable_in is checked live so in-flight samples fall back to the offset.
    assign w_dis = (r_s2_mode == ST_DISABLED) || !enable_in;

    always_comb begin
        w_int_next = r_int;
        if (int_clear_in || !enable_in) begin
            w_int_next = '0;
        end else if (r_s2_vld) begin
            if (r_s2_mode == ST_DISABLED) begin
                w_int_next = '0;
            end else if ((r_s2_mode == ST_HOLD) || w_windup) begin
                w_int_next = w_base;
            end else begin
                w_int_next = w_int_sum;
            end
        end
    end

    assign w_i_hi = w_int_next[IW-1:I_SHIFT];
    assign w_pi   = {{(SUM_W-33){r_s2_p[32]}}, r_s2_p} + {{(SUM_W-IO_W){w_i_hi[IO_W-1]}}, w_i_hi};

    pi_servo_filter_sat_add #(.W_A(SUM_W), .W_B(16), .W_O(16)) u_out_add (
        .i_a   (w_pi),
        .i_b   (offset_in),
        .o_y   (w_dac_sat),
        .o_ovf (w_dac_ovf)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_int    <= '0;
            r_dac    <= '0;
            r_valid  <= 1'b0;
            r_railed <= 1'b0;
        end else begin
            r_int   <= w_int_next;
            r_valid <= r_s2_vld;
            if (r_s2_vld) begin
                if (w_dis) begin
                    r_dac    <= offset_in;
                    r_railed <= 1'b0;
                end else begin
                    r_dac    <= w_dac_sat;
                    r_railed <= w_dac_ovf;
                end
            end
        end
    end

    assign dac_out       = r_dac;
    assign dac_valid_out = r_valid;
    assign railed_out    = r_railed;

endmodule
